risc_v_mike_mem_responder: RTL and testbench

//  Target (responder) end of the core memory bus: accepts word read/write requests from the

---
 rtl/risc_v_mike_mem_responder_pkg.sv | 37 +++
 rtl/risc_v_mike_mem_responder_sram.sv | 45 ++++
 rtl/risc_v_mike_mem_responder.sv | 236 +++++++++++++++++++++++
 tb/tb_risc_v_mike_mem_responder.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_v_mike_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// risc_v_mike_mem_responder_pkg
//   Shared types and constants for the memory-bus responder and its storage.
//   Contents:
//     t_resp_state     responder FSM states (idle / wait states / response)
//     t_rdata_sel      source of the response read data
//     MEM_RESP_WAIT_W  width of the wait-state counter (supports 0..15 waits)
//     resp_lane_mask   expands a 4-bit byte enable to a 32-bit bit mask
// -----------------------------------------------------------------------------
package risc_v_mike_mem_responder_pkg;

  localparam int MEM_RESP_WAIT_W = 4;

  typedef enum logic [1:0] {
    RESP_IDLE = 2'd0,
    RESP_WAIT = 2'd1,
    RESP_RESP = 2'd2
  } t_resp_state;

  // What rsp_rdata shows: nothing (writes, errors, after reset),
  // the storage array, or the access counter snapshot.
  typedef enum logic [1:0] {
    RDSEL_ZERO = 2'd0,
    RDSEL_MEM  = 2'd1,
    RDSEL_CNT  = 2'd2
  } t_rdata_sel;

  function automatic logic [31:0] resp_lane_mask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/risc_v_mike_mem_responder_sram.sv
// -----------------------------------------------------------------------------
// risc_v_mike_resp_sram
//   DEPTH x 32-bit word storage with byte-masked synchronous write and
//   registered synchronous read through a single shared address. The array is
//   split into four byte-wide lanes so each lane maps cleanly onto a block RAM
//   with its own write enable. Contents are never reset.
//   Ports:
//     clk       clock
//     wr_en     write strobe; lanes with be[i]=1 are updated
//     rd_en     read strobe; rdata updates on the next edge, holds otherwise
//     addr      word index
//     be        byte enables for the write
//     wdata     write data
//     rdata     registered read data
// -----------------------------------------------------------------------------
module risc_v_mike_resp_sram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];
    logic [7:0] lane_rd_q;

    always_ff @(posedge clk) begin
      if (wr_en && be[gi]) begin
        lane_mem[addr] <= wdata[8*gi +: 8];
      end
      if (rd_en) begin
        lane_rd_q <= lane_mem[addr];
      end
    end

    assign rdata[8*gi +: 8] = lane_rd_q;
  end

endmodule

// File: rtl/risc_v_mike_mem_responder.sv
// -----------------------------------------------------------------------------
// risc_v_mike_mem_responder
//   Responder end of the core memory bus. Accepts one word read/write request
//   at a time in IDLE, waits WAIT_STATES cycles, then presents a one-cycle
//   response with read data or an error flag. Storage lives in
//   risc_v_mike_resp_sram; decode, FSM and the optional counter live here.
//
//   Optional feature (macro MEM_RESP_ACCESS_CNT_EN):
//     a read-only 32-bit count of successful accesses at byte address
//     BASE_ADDR+4*DEPTH. Without the macro that address errors.
//
//   Ports:
//     clk        clock
//     rst        asynchronous active-high reset
//     req_val    request valid
//     req_rdy    responder can accept (only in IDLE)
//     req_write  1 = write, 0 = read
//     req_addr   byte address
//     req_wdata  write data
//     req_be     write byte enables
//     rsp_val    one-cycle response pulse
//     rsp_rdata  read data (0 for writes/errors), held between responses
//     rsp_err    access error, held between responses
// -----------------------------------------------------------------------------
module risc_v_mike_mem_responder
  import risc_v_mike_mem_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_val,
  output logic        req_rdy,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_val,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] WIN_BYTES = 32'(4 * DEPTH);
  localparam logic [MEM_RESP_WAIT_W-1:0] WAIT_LOAD =
    (WAIT_STATES > 0) ? MEM_RESP_WAIT_W'(WAIT_STATES - 1) : '0;

  t_resp_state                state_q;
  logic [MEM_RESP_WAIT_W-1:0] wait_cnt_q;
  logic                       write_q;
  logic [31:0]                addr_q;
  logic [31:0]                wdata_q;
  logic [3:0]                 be_q;
  logic                       req_rdy_q;
  logic                       rsp_val_q;
  logic                       rsp_err_q;
  t_rdata_sel                 rdata_sel_q;

  logic        accept;
  logic        enter_resp;
  logic        cur_write;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [3:0]  cur_be;
  logic [31:0] offset;
  logic        below_base;
  logic        misaligned;
  logic        in_mem;
  logic        is_cnt;
  logic        acc_err;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata;
  logic [31:0] cnt_rdata;

  assign accept = req_val && req_rdy_q && (state_q == RESP_IDLE);

  // The edge that moves into RESP is where the access is performed: either
  // the accept edge itself (no wait states) or the last wait-state edge.
  assign enter_resp = ((state_q == RESP_IDLE) && accept && (WAIT_STATES == 0)) ||
                      ((state_q == RESP_WAIT) && (wait_cnt_q == '0));

  // With zero wait states the access happens on the accept edge, so the
  // request fields come straight from the bus instead of the latches.
  always_comb begin
    if (state_q == RESP_IDLE) begin
      cur_write = req_write;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
      cur_be    = req_be;
    end else begin
      cur_write = write_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_be    = be_q;
    end
  end

  // The explicit below-base test keeps addresses under the window from
  // wrapping into it through the unsigned subtraction.
  assign offset     = cur_addr - BASE_ADDR;
  assign below_base = (cur_addr < BASE_ADDR);
  assign misaligned = (cur_addr[1:0] != 2'b00);
  assign in_mem     = !below_base && !misaligned && (offset < WIN_BYTES);

`ifdef MEM_RESP_ACCESS_CNT_EN
  assign is_cnt = !below_base && !misaligned && (offset == WIN_BYTES);
`else
  assign is_cnt = 1'b0;
`endif

  // The counter is read-only: a write to it is an error.
  assign acc_err = !(in_mem || (is_cnt && !cur_write));

  assign mem_we = enter_resp && cur_write && in_mem;
  assign mem_re = enter_resp && !cur_write && in_mem;

  risc_v_mike_resp_sram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_sram (
    .clk   (clk),
    .wr_en (mem_we),
    .rd_en (mem_re),
    .addr  (offset[AW+1:2]),
    .be    (cur_be),
    .wdata (cur_wdata & resp_lane_mask(cur_be)),
    .rdata (mem_rdata)
  );

  // FSM with registered handshake/response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RESP_IDLE;
      wait_cnt_q  <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      req_rdy_q   <= 1'b1;
      rsp_val_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      rdata_sel_q <= RDSEL_ZERO;
    end else begin
      rsp_val_q <= 1'b0;

      // Response fields only change on the edge entering RESP so they hold
      // their value for the rest of the time.
      if (enter_resp) begin
        rsp_val_q <= 1'b1;
        rsp_err_q <= acc_err;
        if (acc_err || cur_write) begin
          rdata_sel_q <= RDSEL_ZERO;
        end else if (is_cnt) begin
          rdata_sel_q <= RDSEL_CNT;
        end else begin
          rdata_sel_q <= RDSEL_MEM;
        end
      end

      case (state_q)
        RESP_IDLE: begin
          if (accept) begin
            write_q   <= req_write;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            be_q      <= req_be;
            req_rdy_q <= 1'b0;
            if (WAIT_STATES == 0) begin
              state_q <= RESP_RESP;
            end else begin
              state_q    <= RESP_WAIT;
              wait_cnt_q <= WAIT_LOAD;
            end
          end
        end
        RESP_WAIT: begin
          if (wait_cnt_q == '0) begin
            state_q <= RESP_RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q - 1'b1;
          end
        end
        RESP_RESP: begin
          state_q   <= RESP_IDLE;
          req_rdy_q <= 1'b1;
        end
        default: begin
          state_q   <= RESP_IDLE;
          req_rdy_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef MEM_RESP_ACCESS_CNT_EN
  logic [31:0] acc_cnt_q;
  logic [31:0] cnt_snap_q;

  // Snapshot on the edge entering RESP gives the count before the current
  // access; the count itself advances at the end of the RESP cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_cnt_q  <= '0;
      cnt_snap_q <= '0;
    end else begin
      if (enter_resp) begin
        cnt_snap_q <= acc_cnt_q;
      end
      if ((state_q == RESP_RESP) && !rsp_err_q) begin
        acc_cnt_q <= acc_cnt_q + 32'd1;
      end
    end
  end

  assign cnt_rdata = cnt_snap_q;
`else
  assign cnt_rdata = '0;
`endif

  always_comb begin
    rsp_rdata = '0;
    case (rdata_sel_q)
      RDSEL_MEM: rsp_rdata = mem_rdata;
      RDSEL_CNT: rsp_rdata = cnt_rdata;
      default:   rsp_rdata = '0;
    endcase
  end

  assign req_rdy = req_rdy_q;
  assign rsp_val = rsp_val_q;
  assign rsp_err = rsp_err_q;

endmodule

// File: tb/tb_risc_v_mike_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_risc_v_mike_mem_responder
//   Randomised scoreboard bench. A driver issues requests and pushes the
//   expected response (data, error, due cycle) computed by a word-array model;
//   a monitor pops and compares on every rsp_val. A second instance with three
//   wait states exercises reset in the middle of a write.
// -----------------------------------------------------------------------------
module tb_risc_v_mike_mem_responder;

  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int          DEPTH = 1024;
  localparam int          WS    = 1;
  localparam longint      WIN_END = longint'(BASE) + 4 * DEPTH;
`ifdef MEM_RESP_ACCESS_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- main instance (WAIT_STATES = 1) ----------------
  logic        rst;
  logic        req_val, req_rdy, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_val, rsp_err;
  logic [31:0] rsp_rdata;

  risc_v_mike_mem_responder #(
    .BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_STATES(WS)
  ) dut (
    .clk(clk), .rst(rst), .req_val(req_val), .req_rdy(req_rdy),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_be(req_be), .rsp_val(rsp_val), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  // ---------------- second instance (WAIT_STATES = 3) ----------------
  logic        b_rst;
  logic        b_req_val, b_req_rdy, b_req_write;
  logic [31:0] b_req_addr, b_req_wdata;
  logic [3:0]  b_req_be;
  logic        b_rsp_val, b_rsp_err;
  logic [31:0] b_rsp_rdata;

  risc_v_mike_mem_responder #(
    .BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_STATES(3)
  ) dut3 (
    .clk(clk), .rst(b_rst), .req_val(b_req_val), .req_rdy(b_req_rdy),
    .req_write(b_req_write), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .req_be(b_req_be), .rsp_val(b_rsp_val), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  // ---------------- reference model ----------------
  logic [31:0] mdl_mem [int];
  int unsigned mdl_cnt = 0;

  task automatic model(input bit w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, output logic [31:0] rd, output bit err);
    longint la;
    bit     is_cnt;
    int     idx;
    logic [31:0] word;
    la     = longint'(a);
    is_cnt = CNT_EN && (la == WIN_END);
    err    = (la % 4 != 0) || (la < longint'(BASE)) || (la > WIN_END) ||
             (la == WIN_END && !is_cnt) || (is_cnt && w);
    rd     = 32'h0;
    if (!err) begin
      if (is_cnt) begin
        rd = mdl_cnt;
      end else begin
        idx = int'((la - longint'(BASE)) / 4);
        if (w) begin
          word = mdl_mem.exists(idx) ? mdl_mem[idx] : 32'hx;
          for (int i = 0; i < 4; i++)
            if (be[i]) word[8*i +: 8] = wd[8*i +: 8];
          mdl_mem[idx] = word;
        end else begin
          rd = mdl_mem.exists(idx) ? mdl_mem[idx] : 32'hx;
        end
      end
      mdl_cnt = mdl_cnt + 1;
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned due;
    logic [31:0] addr;
    bit          w;
  } exp_t;
  exp_t sb_q[$];

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (rsp_val) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL spurious_rsp: cyc=%0d rdata=%h err=%0b, required no response", cyc, rsp_rdata, rsp_err);
        end else begin
          e = sb_q.pop_front();
          if (rsp_rdata !== e.rdata || rsp_err !== e.err || cyc != e.due) begin
            n_fail++;
            $display("FAIL rsp_%s addr=%h: got rdata=%h err=%0b cyc=%0d, required rdata=%h err=%0b cyc=%0d",
                     e.w ? "wr" : "rd", e.addr, rsp_rdata, rsp_err, cyc, e.rdata, e.err, e.due);
          end else begin
            $display("rsp %s addr=%h rdata=%h err=%0b cyc=%0d ok", e.w ? "wr" : "rd", e.addr, rsp_rdata, rsp_err, cyc);
          end
        end
      end else if (sb_q.size() > 0 && cyc > sb_q[0].due) begin
        e = sb_q.pop_front();
        n_checks++;
        n_fail++;
        $display("FAIL rsp_missing addr=%h: no rsp_val by cyc=%0d, required at cyc=%0d", e.addr, cyc, e.due);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, output int unsigned acc);
    exp_t e;
    logic [31:0] rd;
    bit er;
    int k;
    req_write = w; req_addr = a; req_wdata = wd; req_be = be; req_val = 1'b1;
    k = 0;
    while (!req_rdy && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!req_rdy) begin
      n_checks++; n_fail++;
      $display("FAIL req_rdy_timeout addr=%h: req_rdy=0 after 100 cycles, required 1", a);
      req_val = 1'b0;
      acc = 0;
      return;
    end
    acc = cyc;
    model(w, a, wd, be, rd, er);
    e.rdata = rd; e.err = er; e.due = cyc + 1 + WS; e.addr = a; e.w = w;
    sb_q.push_back(e);
    @(negedge clk);
    req_val = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end else begin
      $display("check %s = %h ok", nm, act);
    end
  endtask

  // Single request on the WAIT_STATES=3 instance; returns response and latency.
  task automatic b_do(input bit w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] be, output logic [31:0] rd,
                      output logic er, output int lat);
    int unsigned acc;
    int k;
    b_req_write = w; b_req_addr = a; b_req_wdata = wd; b_req_be = be; b_req_val = 1'b1;
    k = 0;
    while (!b_req_rdy && k < 50) begin @(negedge clk); k++; end
    acc = cyc;
    @(negedge clk);
    b_req_val = 1'b0;
    k = 0;
    while (!b_rsp_val && k < 20) begin @(negedge clk); k++; end
    rd  = b_rsp_rdata;
    er  = b_rsp_err;
    lat = b_rsp_val ? int'(cyc - acc) : -1;
  endtask

  function automatic logic [31:0] word_addr(input int sel);
    int idx;
    idx = (sel < 16) ? sel : (DEPTH - 32 + sel);
    return BASE + 32'(4 * idx);
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int unsigned a0, a1, acc;
    logic [31:0] bad [7];
    logic [31:0] rd;
    logic er;
    int lat, k;

    bad[0] = BASE + 32'd2;
    bad[1] = BASE - 32'd4;
    bad[2] = BASE + 32'(4 * DEPTH);
    bad[3] = 32'h0000_0000;
    bad[4] = 32'hFFFF_FFFC;
    bad[5] = BASE + 32'(4 * DEPTH) + 32'd4;
    bad[6] = BASE + 32'd1;

    rst = 1'b1; req_val = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    b_rst = 1'b1; b_req_val = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_be = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0; b_rst = 1'b0;

    // reset state
    chk("reset_req_rdy", 32'(req_rdy), 32'd1);
    chk("reset_rsp_val", 32'(rsp_val), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);

    // write then read at first ready: responses at +2 and +5, accepts 3 apart
    issue(1'b1, BASE + 32'd8, 32'hDEAD_BEEF, 4'hF, a0);
    issue(1'b0, BASE + 32'd8, 32'h0, 4'h0, a1);
    chk("throughput_accept_gap", 32'(a1 - a0), 32'(WS + 2));

    // byte lanes
    issue(1'b1, BASE + 32'd12, 32'h1122_3344, 4'hF, acc);
    issue(1'b1, BASE + 32'd12, 32'hAABB_CCDD, 4'b0101, acc);
    issue(1'b0, BASE + 32'd12, 32'h0, 4'h0, acc);
    issue(1'b1, BASE + 32'd12, 32'hFFFF_FFFF, 4'h0, acc);
    issue(1'b0, BASE + 32'd12, 32'h0, 4'h0, acc);

    // initialise the random working set (low and high ends of the window)
    for (int i = 0; i < 32; i++)
      issue(1'b1, word_addr(i), $urandom, 4'hF, acc);

    // errors leave the array untouched
    issue(1'b0, word_addr(0), 32'h0, 4'h0, acc);
    for (int i = 0; i < 7; i++)
      issue(1'b1, bad[i], 32'h5A5A_5A5A, 4'hF, acc);
    for (int i = 0; i < 7; i++)
      issue(1'b0, bad[i], 32'h0, 4'h0, acc);
    issue(1'b0, word_addr(0), 32'h0, 4'h0, acc);
    issue(1'b0, word_addr(31), 32'h0, 4'h0, acc);

    // randomised traffic
    for (int t = 0; t < 200; t++) begin
      logic [31:0] a;
      if ($urandom_range(0, 99) < 15) a = bad[$urandom_range(0, 6)];
      else                            a = word_addr(int'($urandom_range(0, 31)));
      issue(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), acc);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // access counter readback (errors when the feature is absent)
    issue(1'b0, bad[2], 32'h0, 4'h0, acc);

    k = 0;
    while (sb_q.size() > 0 && k < 100) begin @(negedge clk); k++; end
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    // reset in the middle of a write on the WAIT_STATES=3 instance
    b_do(1'b1, BASE + 32'd20, 32'hCAFE_F00D, 4'hF, rd, er, lat);
    chk("ws3_write_latency", 32'(lat), 32'd4);
    chk("ws3_write_err", 32'(er), 32'd0);
    b_req_write = 1'b1; b_req_addr = BASE + 32'd20; b_req_wdata = 32'h0BAD_BEEF;
    b_req_be = 4'hF; b_req_val = 1'b1;
    @(negedge clk);
    b_req_val = 1'b0;
    @(negedge clk);
    #2 b_rst = 1'b1;
    k = 0;
    repeat (3) begin @(negedge clk); if (b_rsp_val) k++; end
    chk("ws3_reset_rdy", 32'(b_req_rdy), 32'd1);
    #2 b_rst = 1'b0;
    repeat (8) begin @(negedge clk); if (b_rsp_val) k++; end
    chk("ws3_no_rsp_after_reset", 32'(k), 32'd0);
    b_do(1'b0, BASE + 32'd20, 32'h0, 4'h0, rd, er, lat);
    chk("ws3_word_kept", rd, 32'hCAFE_F00D);
    chk("ws3_read_latency", 32'(lat), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule
